// File: rtl/c2f_thread_tracker.sv
// -----------------------------------------------------------------------------
// c2f_thread_tracker
//
// Core-to-fabric remote-access tracker for the GPC data-memory path. Core
// loads/stores whose address is not local to this core are queued into a
// request FIFO toward the ring. One outstanding remote read is tracked per
// hardware thread. The ring response is captured and handed back on the owning
// thread's next Q103H slot, registered at Q104H.
//
// Optional feature macro: C2F_TIMEOUT_EN
//   defined   : per-thread WAIT timeout. On expiry the thread goes to READY
//               with data 32'hDEAD_0000 | thread index and ErrSticky[1] is set.
//   undefined : WAIT is unbounded and ErrSticky[1] is tied to 0.
//
// Ports
//   QClk, RstQnnnH           clock, asynchronous active-high reset
//   CoreIdStrap              local core ID (addr[31:24] == 0 or == strap is local)
//   ThreadQ103H              one-hot thread owning the Q103H slot
//   AddressQ103H/WrDataQ103H core access address / write data
//   RdEnQ103H/WrEnQ103H      core read / write strobes
//   C2F_FullQ103H            access rejected this cycle, core replays it
//   ThreadRcAccess           per-thread freeze (remote read in WAIT or READY)
//   C2F_Req*Q500H            request FIFO head toward the ring
//   C2F_ReqReady             ring accepts the head this cycle
//   C2F_Rsp*Q502H            ring response
//   C2F_RspMatchQ104H/DataQ104H  delivered remote read data
//   C2F_ErrSticky            bit0 protocol error, bit1 timeout
// -----------------------------------------------------------------------------
package c2f_pkg;
  typedef enum logic {
    C2F_RD = 1'b0,
    C2F_WR = 1'b1
  } t_opcode;
endpackage

module c2f_thread_tracker
  import c2f_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = $clog2(NUM_THREADS),
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                   QClk,
  input  logic                   RstQnnnH,
  input  logic [7:0]             CoreIdStrap,
  input  logic [NUM_THREADS-1:0] ThreadQ103H,
  input  logic [31:0]            AddressQ103H,
  input  logic [31:0]            WrDataQ103H,
  input  logic                   RdEnQ103H,
  input  logic                   WrEnQ103H,
  output logic                   C2F_FullQ103H,
  output logic [NUM_THREADS-1:0] ThreadRcAccess,
  output logic                   C2F_ReqValidQ500H,
  input  logic                   C2F_ReqReady,
  output t_opcode                C2F_ReqOpcodeQ500H,
  output logic [TID_W-1:0]       C2F_ReqThreadIDQ500H,
  output logic [31:0]            C2F_ReqAddressQ500H,
  output logic [31:0]            C2F_ReqDataQ500H,
  input  logic                   C2F_RspValidQ502H,
  input  logic [TID_W-1:0]       C2F_RspThreadIDQ502H,
  input  logic [31:0]            C2F_RspDataQ502H,
  output logic                   C2F_RspMatchQ104H,
  output logic [31:0]            C2F_RspDataQ104H,
  output logic [1:0]             C2F_ErrSticky
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } t_state;

  typedef struct packed {
    t_opcode          op;
    logic [TID_W-1:0] tid;
    logic [31:0]      addr;
    logic [31:0]      data;
  } t_req;

  // Request FIFO storage
  t_req             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Per-thread tracking
  t_state      r_state [NUM_THREADS];
  logic [31:0] r_cap   [NUM_THREADS];

  logic        r_rsp_match;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_err;

  logic                   w_is_local;
  logic                   w_remote;
  logic                   w_fifo_full;
  logic                   w_thr_busy;
  logic [TID_W-1:0]       w_tid;
  logic                   w_rd_err;
  logic                   w_reject;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_valid;
  t_req                   w_head;
  t_req                   w_new;
  logic [NUM_THREADS-1:0] w_rsp_hit;
  logic [NUM_THREADS-1:0] w_deliver;
  logic [NUM_THREADS-1:0] w_rc;
  logic [NUM_THREADS-1:0] w_to_hit;
  logic [31:0]            w_dlv_data;
  logic                   w_rsp_err;

  // Request classification and push/pop decisions
  always_comb begin
    w_is_local  = (AddressQ103H[31:24] == 8'h00) || (AddressQ103H[31:24] == CoreIdStrap);
    w_remote    = (RdEnQ103H || WrEnQ103H) && !w_is_local;
    // Fullness uses the current count only: a same-cycle pop does not make room.
    w_fifo_full = (r_count == CNT_W'(FIFO_DEPTH));
    w_thr_busy  = 1'b0;
    w_tid       = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_tid      = w_tid | (ThreadQ103H[i] ? TID_W'(i) : TID_W'(0));
      w_thr_busy = w_thr_busy | (ThreadQ103H[i] && (r_state[i] != ST_IDLE));
    end
    // A second remote read while one is outstanding is a protocol error.
    w_rd_err = w_remote && RdEnQ103H && w_thr_busy;
    w_reject = w_remote && (w_fifo_full || w_rd_err);
    w_push   = w_remote && !w_reject;
    w_pop    = (r_count != CNT_W'(0)) && C2F_ReqReady;
    w_new.op   = WrEnQ103H ? C2F_WR : C2F_RD;
    w_new.tid  = w_tid;
    w_new.addr = AddressQ103H;
    w_new.data = WrDataQ103H;
  end

  // Response matching, delivery selection and freeze decode
  always_comb begin
    w_rsp_hit  = '0;
    w_deliver  = '0;
    w_rc       = '0;
    w_dlv_data = 32'h0000_0000;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_rsp_hit[i] = C2F_RspValidQ502H && (C2F_RspThreadIDQ502H == TID_W'(i)) &&
                     (r_state[i] == ST_WAIT);
      w_deliver[i] = ThreadQ103H[i] && (r_state[i] == ST_READY);
      w_rc[i]      = (r_state[i] != ST_IDLE);
      w_dlv_data   = w_dlv_data | (w_deliver[i] ? r_cap[i] : 32'h0000_0000);
    end
    // Any response that does not land on a waiting thread is dropped and flagged.
    w_rsp_err = C2F_RspValidQ502H && !(|w_rsp_hit);
  end

`ifdef C2F_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt [NUM_THREADS];

  // Timeout fires on the last WAIT cycle unless a response wins that cycle
  always_comb begin
    w_to_hit = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_to_hit[i] = (r_state[i] == ST_WAIT) && !w_rsp_hit[i] &&
                    (r_to_cnt[i] == TO_W'(TIMEOUT_CYC - 1));
    end
  end

  // WAIT-cycle counters, held at zero outside WAIT so entry starts from zero
  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      for (int i = 0; i < NUM_THREADS; i++) r_to_cnt[i] <= TO_W'(0);
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (r_state[i] == ST_WAIT) r_to_cnt[i] <= r_to_cnt[i] + TO_W'(1);
        else                       r_to_cnt[i] <= TO_W'(0);
      end
    end
  end
`else
  logic w_unused_timeout;
  assign w_to_hit         = '0;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // Request FIFO: pointers, occupancy and storage
  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Per-thread remote-read state machines and captured data
  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_state[i] <= ST_IDLE;
        r_cap[i]   <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            // Writes are posted; only an accepted read arms the tracker.
            if (w_push && RdEnQ103H && ThreadQ103H[i]) r_state[i] <= ST_WAIT;
          end
          ST_WAIT: begin
            if (w_rsp_hit[i]) begin
              r_cap[i]   <= C2F_RspDataQ502H;
              r_state[i] <= ST_READY;
            end else if (w_to_hit[i]) begin
              r_cap[i]   <= 32'hDEAD_0000 | 32'(i);
              r_state[i] <= ST_READY;
            end
          end
          ST_READY: begin
            if (ThreadQ103H[i]) begin
              r_cap[i]   <= 32'h0000_0000;
              r_state[i] <= ST_IDLE;
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  // Q104H delivery registers and sticky error flags
  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      r_rsp_match <= 1'b0;
      r_rsp_data  <= 32'h0000_0000;
      r_err       <= 2'b00;
    end else begin
      r_rsp_match <= |w_deliver;
      r_rsp_data  <= w_dlv_data;
      r_err[0]    <= r_err[0] | w_rsp_err | w_rd_err;
      r_err[1]    <= r_err[1] | (|w_to_hit);
    end
  end

  // Head-of-FIFO view; all request fields read as zero when empty
  always_comb begin
    w_valid = (r_count != CNT_W'(0));
    w_head  = r_mem[r_rd_ptr];
    if (w_valid) begin
      C2F_ReqOpcodeQ500H   = w_head.op;
      C2F_ReqThreadIDQ500H = w_head.tid;
      C2F_ReqAddressQ500H  = w_head.addr;
      C2F_ReqDataQ500H     = w_head.data;
    end else begin
      C2F_ReqOpcodeQ500H   = C2F_RD;
      C2F_ReqThreadIDQ500H = TID_W'(0);
      C2F_ReqAddressQ500H  = 32'h0000_0000;
      C2F_ReqDataQ500H     = 32'h0000_0000;
    end
  end

  // Rejection is suppressed while reset is asserted so every output reads zero.
  assign C2F_FullQ103H     = w_reject && !RstQnnnH;
  assign C2F_ReqValidQ500H = w_valid;
  assign ThreadRcAccess    = w_rc;
  assign C2F_RspMatchQ104H = r_rsp_match;
  assign C2F_RspDataQ104H  = r_rsp_data;
  assign C2F_ErrSticky     = r_err;

endmodule

// File: tb/tb_c2f_thread_tracker.sv
// -----------------------------------------------------------------------------
// tb_c2f_thread_tracker
//
// Directed testbench for c2f_thread_tracker. A table of per-cycle vectors
// (inputs plus expected outputs) covers remote read round trip, FIFO fill and
// drain with backpressure, local accesses and the double-read protocol error.
// Hand-written sequences cover asynchronous reset with traffic in flight, a
// response to an idle thread, and (with C2F_TIMEOUT_EN) the WAIT timeout.
// -----------------------------------------------------------------------------
module tb_c2f_thread_tracker;
  import c2f_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  core_id;
  logic [3:0]  thr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic        full;
  logic [3:0]  rc;
  logic        req_val;
  logic        req_rdy;
  t_opcode     req_op;
  logic [1:0]  req_tid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_val;
  logic [1:0]  rsp_tid;
  logic [31:0] rsp_data;
  logic        match;
  logic [31:0] match_data;
  logic [1:0]  err;

  int n_chk;
  int n_fail;

  c2f_thread_tracker #(
    .NUM_THREADS(4),
    .TID_W(2),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYC(8)
  ) dut (
    .QClk                 (clk),
    .RstQnnnH             (rst),
    .CoreIdStrap          (core_id),
    .ThreadQ103H          (thr),
    .AddressQ103H         (addr),
    .WrDataQ103H          (wdata),
    .RdEnQ103H            (rd_en),
    .WrEnQ103H            (wr_en),
    .C2F_FullQ103H        (full),
    .ThreadRcAccess       (rc),
    .C2F_ReqValidQ500H    (req_val),
    .C2F_ReqReady         (req_rdy),
    .C2F_ReqOpcodeQ500H   (req_op),
    .C2F_ReqThreadIDQ500H (req_tid),
    .C2F_ReqAddressQ500H  (req_addr),
    .C2F_ReqDataQ500H     (req_data),
    .C2F_RspValidQ502H    (rsp_val),
    .C2F_RspThreadIDQ502H (rsp_tid),
    .C2F_RspDataQ502H     (rsp_data),
    .C2F_RspMatchQ104H    (match),
    .C2F_RspDataQ104H     (match_data),
    .C2F_ErrSticky        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  thr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic        rdy;
    logic        rv;
    logic [1:0]  rtid;
    logic [31:0] rdat;
    logic        e_full;
    logic        e_val;
    logic        e_op;
    logic [1:0]  e_tid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_rc;
    logic        e_m;
    logic [31:0] e_md;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w, input logic rdy,
                       input logic rv, input logic [1:0] rt, input logic [31:0] rdat);
    thr = t; addr = a; wdata = d; rd_en = r; wr_en = w; req_rdy = rdy;
    rsp_val = rv; rsp_tid = rt; rsp_data = rdat;
  endtask

  task automatic idle_in(input logic rdy);
    drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, rdy, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic check_vec(input int k, input vec_t v);
    chk($sformatf("v%0d.full", k),   {31'h0, full},       {31'h0, v.e_full});
    chk($sformatf("v%0d.valid", k),  {31'h0, req_val},    {31'h0, v.e_val});
    chk($sformatf("v%0d.opcode", k), {31'h0, req_op},     {31'h0, v.e_op});
    chk($sformatf("v%0d.tid", k),    {30'h0, req_tid},    {30'h0, v.e_tid});
    chk($sformatf("v%0d.addr", k),   req_addr,            v.e_addr);
    chk($sformatf("v%0d.data", k),   req_data,            v.e_data);
    chk($sformatf("v%0d.rc", k),     {28'h0, rc},         {28'h0, v.e_rc});
    chk($sformatf("v%0d.match", k),  {31'h0, match},      {31'h0, v.e_m});
    chk($sformatf("v%0d.mdata", k),  match_data,          v.e_md);
    chk($sformatf("v%0d.err", k),    {30'h0, err},        {30'h0, v.e_err});
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    core_id = 8'h01;
    idle_in(1'b0);

    // --- T1 remote read round trip -----------------------------------------
    //                 thr      addr          wd           rd   wr   rdy  rv   rtid  rdat           full val  op   tid   addr          data          rc       m    mdata          err
    vq.push_back(vec_t'{4'b0010, 32'h0200_1000, 32'h0,        1'b1,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b0,2'd1,32'h0200_1000, 32'h0,        4'b0010,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0010,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0010,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0010,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b1,2'd1,32'hCAFE_F00D, 1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0010,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0001, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0010,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0010, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0010,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b1,32'hCAFE_F00D, 2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    // --- FIFO fill under backpressure, reject when full, ordered drain ------
    vq.push_back(vec_t'{4'b0001, 32'h0300_0000, 32'h1111_0000,1'b0,1'b1,1'b0,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0010, 32'h0300_0004, 32'h2222_0001,1'b0,1'b1,1'b0,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd0,32'h0300_0000, 32'h1111_0000,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0100, 32'h0300_0008, 32'h3333_0002,1'b0,1'b1,1'b0,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd0,32'h0300_0000, 32'h1111_0000,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b1000, 32'h0300_000C, 32'h4444_0003,1'b0,1'b1,1'b0,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd0,32'h0300_0000, 32'h1111_0000,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0001, 32'h0300_0010, 32'h5555_0004,1'b0,1'b1,1'b0,1'b0,2'd0,32'h0,         1'b1,1'b1,1'b1,2'd0,32'h0300_0000, 32'h1111_0000,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0001, 32'h0300_0010, 32'h5555_0004,1'b0,1'b1,1'b1,1'b0,2'd0,32'h0,         1'b1,1'b1,1'b1,2'd0,32'h0300_0000, 32'h1111_0000,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd1,32'h0300_0004, 32'h2222_0001,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd2,32'h0300_0008, 32'h3333_0002,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd2,32'h0300_0008, 32'h3333_0002,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd2,32'h0300_0008, 32'h3333_0002,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd3,32'h0300_000C, 32'h4444_0003,4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    // --- local accesses: addr[31:24] == 0 and == CoreIdStrap ----------------
    vq.push_back(vec_t'{4'b0001, 32'h0000_1234, 32'h0,        1'b1,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0010, 32'h0100_0040, 32'h0000_AAAA,1'b0,1'b1,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    // --- double read from T0, then delivery concurrent with a T0 write push -
    vq.push_back(vec_t'{4'b0001, 32'h0400_0000, 32'h0,        1'b1,1'b0,1'b0,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0001, 32'h0400_0004, 32'h0,        1'b1,1'b0,1'b0,1'b0,2'd0,32'h0,         1'b1,1'b1,1'b0,2'd0,32'h0400_0000, 32'h0,        4'b0001,1'b0,32'h0,         2'b00});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b0,2'd0,32'h0400_0000, 32'h0,        4'b0001,1'b0,32'h0,         2'b01});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b1,2'd0,32'h0BAD_CAFE, 1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0001,1'b0,32'h0,         2'b01});
    vq.push_back(vec_t'{4'b0001, 32'h0500_0000, 32'h0000_0077,1'b0,1'b1,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0001,1'b0,32'h0,         2'b01});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b1,1'b1,2'd0,32'h0500_0000, 32'h0000_0077,4'b0000,1'b1,32'h0BAD_CAFE, 2'b01});
    vq.push_back(vec_t'{4'b0000, 32'h0,         32'h0,        1'b0,1'b0,1'b1,1'b0,2'd0,32'h0,         1'b0,1'b0,1'b0,2'd0,32'h0,         32'h0,        4'b0000,1'b0,32'h0,         2'b01});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.valid", {31'h0, req_val}, 32'h0);
    chk("reset.rc",    {28'h0, rc},      32'h0);
    chk("reset.err",   {30'h0, err},     32'h0);
    chk("reset.match", {31'h0, match},   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven cycles
    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].thr, vq[k].addr, vq[k].wd, vq[k].rd, vq[k].wr, vq[k].rdy,
            vq[k].rv, vq[k].rtid, vq[k].rdat);
      @(negedge clk);
      check_vec(k, vq[k]);
      @(posedge clk); #1;
    end

    // Reset with T3 in WAIT and two FIFO entries
    drive(4'b1000, 32'h0600_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    @(posedge clk); #1;
    drive(4'b0001, 32'h0600_0004, 32'h0000_0099, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
    @(posedge clk); #1;
    idle_in(1'b0);
    @(negedge clk);
    chk("prerst.valid", {31'h0, req_val}, 32'h1);
    chk("prerst.tid",   {30'h0, req_tid}, 32'h3);
    chk("prerst.rc",    {28'h0, rc},      32'h8);
    rst = 1'b1;
    drive(4'b0010, 32'h0700_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    #1;
    chk("rst.valid", {31'h0, req_val}, 32'h0);
    chk("rst.addr",  req_addr,         32'h0);
    chk("rst.rc",    {28'h0, rc},      32'h0);
    chk("rst.err",   {30'h0, err},     32'h0);
    chk("rst.full",  {31'h0, full},    32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h3333_3333);
    @(negedge clk);
    chk("late.err_before", {30'h0, err}, 32'h0);
    @(posedge clk); #1;
    drive(4'b1000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    chk("late.err",   {30'h0, err},     32'h1);
    chk("late.rc",    {28'h0, rc},      32'h0);
    chk("late.valid", {31'h0, req_val}, 32'h0);
    @(posedge clk); #1;
    idle_in(1'b1);
    @(negedge clk);
    chk("late.match", {31'h0, match}, 32'h0);

    // Response to idle thread 2 after a fresh reset
    rst = 1'b1;
    #1;
    chk("rst2.err", {30'h0, err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1234_5678);
    @(posedge clk); #1;
    idle_in(1'b1);
    @(negedge clk);
    chk("idle_rsp.err", {30'h0, err}, 32'h1);
    chk("idle_rsp.rc",  {28'h0, rc},  32'h0);

`ifdef C2F_TIMEOUT_EN
    // Timeout: T1 read with no response
    @(posedge clk); #1;
    drive(4'b0010, 32'h0200_2000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
    @(posedge clk); #1;
    idle_in(1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("to.wait%0d.err", k), {30'h0, err}, 32'h1);
      chk($sformatf("to.wait%0d.rc", k),  {28'h0, rc},  32'h2);
      @(posedge clk); #1;
    end
    drive(4'b0010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    chk("to.err", {30'h0, err}, 32'h3);
    chk("to.rc",  {28'h0, rc},  32'h2);
    @(posedge clk); #1;
    idle_in(1'b1);
    @(negedge clk);
    chk("to.match", {31'h0, match}, 32'h1);
    chk("to.mdata", match_data,     32'hDEAD_0001);
    chk("to.rc_off", {28'h0, rc},   32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
